iobus_initiator: RTL and testbench

IOBUS_INITIATOR -- requirements
Module: iobus_initiator

---
 rtl/iobus_pkg.sv | 35 +++
 rtl/iobus_cmd_fifo.sv | 59 +++++
 rtl/iobus_initiator.sv | 119 +++++++++++
 tb/tb_iobus_initiator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/iobus_pkg.sv
`default_nettype none
//============================================================================
// Module      : iobus_pkg
// Description : Shared definitions for the IOBUS initiator: MMIO address
//               map constants, the queued command record, the initiator
//               FSM state encoding and an address legality helper.
// Revision    : 1.0 - initial release
//============================================================================
package iobus_pkg;

    localparam logic [31:0] SWITCHES_AD = 32'h1100_0000;
    localparam logic [31:0] LEDS_AD     = 32'h1100_0020;
    localparam logic [31:0] SSEG_AD     = 32'h1100_0040;
    localparam logic [31:0] MMIO_LO     = 32'h1100_0000;
    localparam logic [31:0] MMIO_HI     = 32'h1100_00FF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Word-aligned and inside the MMIO window.
    function automatic logic addr_legal(input logic [31:0] a);
        return (a >= MMIO_LO) && (a <= MMIO_HI) && (a[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iobus_cmd_fifo.sv
`default_nettype none
//============================================================================
// Module      : iobus_cmd_fifo
// Description : Command FIFO for the IOBUS initiator. Pointers carry one
//               extra wrap bit so full and empty are distinguishable.
//               Push is ignored when full, pop is ignored when empty;
//               simultaneous push and pop leaves occupancy unchanged.
// Ports       : clk_i, rst_i (sync, active-high), push_i/din_i,
//               pop_i/dout_o (show-ahead head), full_o, empty_o
// Revision    : 1.0 - initial release
//============================================================================
module iobus_cmd_fifo
    import iobus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  cmd_t din_i,
    input  logic pop_i,
    output cmd_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    cmd_t        mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        w_push;
    logic        w_pop;

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + PTR_ONE;
            if (w_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only observed between pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/iobus_initiator.sv
`default_nettype none
//============================================================================
// Module      : iobus_initiator
// Description : Queues MMIO commands and issues each one as a single-cycle
//               IOBUS transaction, then holds the response until consumed.
//               FSM: IDLE -> ISSUE (one cycle) -> RESP (until RSP_READY).
// Ports       : CLK, RST (sync, active-high)
//               CMD_VALID/CMD_READY/CMD_WE/CMD_ADDR/CMD_DATA - command in
//               RSP_VALID/RSP_READY/RSP_DATA/RSP_ERR         - response out
//               BUSY                                         - work pending
//               IOBUSADDR/IOBUSOUT/IOBUSWR/IOBUSIN           - IOBUS side
// Config      : IOBUS_ADDR_CHECK_EN - when defined, commands outside the
//               MMIO window or not word aligned are not put on the bus and
//               answer with RSP_ERR=1, RSP_DATA=0.
// Revision    : 1.0 - initial release
//============================================================================
module iobus_initiator
    import iobus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WE,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic        BUSY,
    output logic [31:0] IOBUSADDR,
    output logic [31:0] IOBUSOUT,
    output logic        IOBUSWR,
    input  logic [31:0] IOBUSIN
);

    state_e      state_q;
    state_e      state_d;
    cmd_t        cmd_q;
    logic [31:0] rsp_data_q;
    cmd_t        w_head;
    cmd_t        w_cmd_in;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_issue_ok;
    logic        w_drive;

    assign w_cmd_in = '{we: CMD_WE, addr: CMD_ADDR, data: CMD_DATA};
    assign w_pop    = (state_q == ST_IDLE) && !w_empty;

    iobus_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (CMD_VALID),
        .din_i   (w_cmd_in),
        .pop_i   (w_pop),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifdef IOBUS_ADDR_CHECK_EN
    logic rsp_err_q;

    assign w_issue_ok = addr_legal(cmd_q.addr);
    assign RSP_ERR    = rsp_err_q;

    always_ff @(posedge CLK) begin
        if (RST)                        rsp_err_q <= 1'b0;
        else if (state_q == ST_ISSUE)   rsp_err_q <= !w_issue_ok;
    end
`else
    assign w_issue_ok = 1'b1;
    assign RSP_ERR    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!w_empty) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  if (RSP_READY) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_pop) cmd_q <= w_head;
            // Rejected commands and writes both answer with zero data.
            if (state_q == ST_ISSUE)
                rsp_data_q <= (w_issue_ok && !cmd_q.we) ? IOBUSIN : 32'h0;
        end
    end

    // Bus is only driven during ISSUE, and only for accepted addresses.
    assign w_drive   = (state_q == ST_ISSUE) && w_issue_ok;
    assign IOBUSADDR = w_drive ? cmd_q.addr : 32'h0;
    assign IOBUSOUT  = (w_drive && cmd_q.we) ? cmd_q.data : 32'h0;
    assign IOBUSWR   = w_drive && cmd_q.we;

    assign CMD_READY = !w_full;
    assign RSP_VALID = (state_q == ST_RESP);
    assign RSP_DATA  = rsp_data_q;
    assign BUSY      = !w_empty || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iobus_initiator.sv
`default_nettype none
//============================================================================
// Module      : tb_iobus_initiator
// Description : Self-checking bench for iobus_initiator (FIFO_DEPTH=4).
//               Directed vector table plus hand-written sequences for
//               queue back-pressure and reset during ISSUE.
// Config      : IOBUS_ADDR_CHECK_EN changes expectations for bad addresses.
// Revision    : 1.0 - initial release
//============================================================================
module tb_iobus_initiator;

`ifdef IOBUS_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic        CMD_WE = 1'b0;
    logic [31:0] CMD_ADDR = '0;
    logic [31:0] CMD_DATA = '0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b1;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;
    logic        BUSY;
    logic [31:0] IOBUSADDR;
    logic [31:0] IOBUSOUT;
    logic        IOBUSWR;
    logic [31:0] IOBUSIN;

    iobus_initiator #(.FIFO_DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WE    (CMD_WE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .BUSY      (BUSY),
        .IOBUSADDR (IOBUSADDR),
        .IOBUSOUT  (IOBUSOUT),
        .IOBUSWR   (IOBUSWR),
        .IOBUSIN   (IOBUSIN)
    );

    always #5 CLK = ~CLK;

    // Peripheral model: switches read 0x1234, everything else reads ~addr.
    assign IOBUSIN = (IOBUSADDR == 32'h1100_0000) ? 32'h0000_1234 : ~IOBUSADDR;

    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;
    logic prev_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus write monitor: count pulses and flag any multi-cycle pulse.
    always @(negedge CLK) begin
        if (IOBUSWR === 1'b1) begin
            wr_pulses++;
            chk("iobuswr_single_cycle", {31'b0, prev_wr}, 32'd0);
        end
        prev_wr = (IOBUSWR === 1'b1);
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;   // response data when the command is issued
        logic        bad;     // rejected when address checking is enabled
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base;
        int n;
        int got;
        logic issued;

        vecs[0] = '{1'b1, 32'h1100_0020, 32'h0000_A5A5, 32'h0,          1'b0};
        vecs[1] = '{1'b0, 32'h1100_0000, 32'h0,         32'h0000_1234,  1'b0};
        vecs[2] = '{1'b1, 32'h1100_0040, 32'hFFFF_FFFF, 32'h0,          1'b0};
        vecs[3] = '{1'b0, 32'h1100_0044, 32'h1357_9BDF, 32'hEEFF_FFBB,  1'b0};
        vecs[4] = '{1'b1, 32'h2000_0000, 32'h0000_0055, 32'h0,          1'b1};
        vecs[5] = '{1'b1, 32'h1100_0022, 32'h0000_0066, 32'h0,          1'b1};
        vecs[6] = '{1'b0, 32'h2000_0000, 32'h0,         32'hDFFF_FFFF,  1'b1};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_cmd_ready", {31'b0, CMD_READY}, 32'd1);
        chk("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        chk("rst_rsp_data",  RSP_DATA,           32'd0);
        chk("rst_rsp_err",   {31'b0, RSP_ERR},   32'd0);
        chk("rst_busy",      {31'b0, BUSY},      32'd0);
        chk("rst_busaddr",   IOBUSADDR,          32'd0);
        chk("rst_busout",    IOBUSOUT,           32'd0);
        chk("rst_buswr",     {31'b0, IOBUSWR},   32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Single-command vectors with RSP_READY held high
        RSP_READY = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issued = !(vecs[i].bad && CHK);
            base = wr_pulses;
            chk("v_cmd_ready", {31'b0, CMD_READY}, 32'd1);
            CMD_VALID = 1'b1;
            CMD_WE    = vecs[i].we;
            CMD_ADDR  = vecs[i].addr;
            CMD_DATA  = vecs[i].data;
            @(negedge CLK);                   // accepted at edge k
            CMD_VALID = 1'b0;
            chk("v_queued_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
            chk("v_queued_buswr",     {31'b0, IOBUSWR},   32'd0);
            chk("v_queued_busy",      {31'b0, BUSY},      32'd1);
            @(negedge CLK);                   // ISSUE after edge k+1
            chk("v_issue_addr", IOBUSADDR, issued ? vecs[i].addr : 32'h0);
            chk("v_issue_out",  IOBUSOUT,  (issued && vecs[i].we) ? vecs[i].data : 32'h0);
            chk("v_issue_wr",   {31'b0, IOBUSWR}, {31'b0, issued && vecs[i].we});
            @(negedge CLK);                   // RESP after edge k+2
            chk("v_rsp_valid", {31'b0, RSP_VALID}, 32'd1);
            chk("v_rsp_data",  RSP_DATA, issued ? vecs[i].rdata : 32'h0);
            chk("v_rsp_err",   {31'b0, RSP_ERR}, {31'b0, !issued});
            chk("v_rsp_busaddr", IOBUSADDR, 32'h0);
            @(negedge CLK);
            chk("v_done_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
            chk("v_done_busy",      {31'b0, BUSY},      32'd0);
            chk("v_wr_pulses", wr_pulses - base, {31'b0, issued && vecs[i].we});
        end

        // Back-pressure: five reads with responses stalled
        RSP_READY = 1'b0;
        base = wr_pulses;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (CMD_READY !== 1'b1 && n < 20) begin
                @(negedge CLK);
                n++;
            end
            chk("bp_push_ready", {31'b0, CMD_READY}, 32'd1);
            CMD_VALID = 1'b1;
            CMD_WE    = 1'b0;
            CMD_ADDR  = 32'h1100_0010 + 32'(4 * i);
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        chk("bp_full_ready", {31'b0, CMD_READY}, 32'd0);
        chk("bp_busy",       {31'b0, BUSY},      32'd1);
        repeat (3) @(negedge CLK);
        chk("bp_stall_valid", {31'b0, RSP_VALID}, 32'd1);
        chk("bp_stall_data",  RSP_DATA, ~32'h1100_0010);
        chk("bp_stall_ready", {31'b0, CMD_READY}, 32'd0);
        RSP_READY = 1'b1;
        got = 0;
        n   = 0;
        while (got < 5 && n < 60) begin
            if (RSP_VALID === 1'b1) begin
                chk("bp_rsp_order", RSP_DATA, ~(32'h1100_0010 + 32'(4 * got)));
                got++;
            end
            @(negedge CLK);
            n++;
        end
        chk("bp_rsp_count", got, 32'd5);
        repeat (4) @(negedge CLK);
        chk("bp_idle_busy", {31'b0, BUSY}, 32'd0);
        chk("bp_no_writes", wr_pulses - base, 32'd0);

        // Reset during the ISSUE cycle of a write
        CMD_VALID = 1'b1;
        CMD_WE    = 1'b1;
        CMD_ADDR  = 32'h1100_0020;
        CMD_DATA  = 32'h0000_0077;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        @(negedge CLK);
        chk("rs_issue_wr", {31'b0, IOBUSWR}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rs_buswr",     {31'b0, IOBUSWR},   32'd0);
        chk("rs_busaddr",   IOBUSADDR,          32'd0);
        chk("rs_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        chk("rs_busy",      {31'b0, BUSY},      32'd0);
        chk("rs_cmd_ready", {31'b0, CMD_READY}, 32'd1);
        chk("rs_rsp_data",  RSP_DATA,           32'd0);
        RST = 1'b0;
        base = wr_pulses;
        repeat (4) @(negedge CLK);
        chk("rs_no_bus_cycle",  wr_pulses - base,   32'd0);
        chk("rs_rsp_valid_after", {31'b0, RSP_VALID}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
